// File: rtl/multicycle_alu.sv
// multicycle_alu: RV-style integer ALU with valid/ready handshakes on both sides.
// Codes 0-13 and reserved codes finish on the accepting edge; with the optional
// MULTICYCLE_ALU_MULDIV_EN macro defined, codes 14-21 run an iterative shift-add
// multiplier or restoring divider (one bit per cycle, result XLEN+1 edges after accept).
// Without the macro, codes 14-21 are reserved (single-cycle, result 0) and busy is 0.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous abort back to IDLE
//   in_valid / in_ready   request handshake (alu_op, data_one, data_two)
//   out_valid / out_ready result handshake (alu_result, zero)
//   busy                  high while a multiply or divide is iterating
module multicycle_alu #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      alu_op,
    input  logic [XLEN-1:0] data_one,
    input  logic [XLEN-1:0] data_two,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_result,
    output logic            zero,
    output logic            busy
);

`ifdef MULTICYCLE_ALU_MULDIV_EN
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd3} state_t;
`endif

    state_t          state;
    logic            alive;      // low during reset and until the first edge after release
    logic            accept;
    logic            md_op;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] single_res;

    // Ready in IDLE, or in DONE when the current result is being consumed this edge.
    assign in_ready = alive && ((state == IDLE) || ((state == DONE) && out_ready));
    assign accept   = in_valid && in_ready && !flush;
    assign shamt    = data_two[SHW-1:0];

    // Single-cycle operations; branch compares return 0 when the condition holds.
    always_comb begin
        single_res = '0;
        case (alu_op)
            5'd0:    single_res = data_one + data_two;
            5'd1:    single_res = data_one - data_two;
            5'd2:    single_res = data_one << shamt;
            5'd3:    single_res = XLEN'($signed(data_one) < $signed(data_two));
            5'd4:    single_res = XLEN'(data_one < data_two);
            5'd5:    single_res = data_one ^ data_two;
            5'd6:    single_res = XLEN'($signed(data_one) >>> shamt);
            5'd7:    single_res = data_one >> shamt;
            5'd8:    single_res = data_one | data_two;
            5'd9:    single_res = data_one & data_two;
            5'd10:   single_res = (data_one == data_two) ? '0 : '1;
            5'd11:   single_res = (data_one != data_two) ? '0 : '1;
            5'd12:   single_res = ($signed(data_one) <  $signed(data_two)) ? '0 : '1;
            5'd13:   single_res = ($signed(data_one) >= $signed(data_two)) ? '0 : '1;
            default: single_res = '0;
        endcase
    end

`ifdef MULTICYCLE_ALU_MULDIV_EN
    localparam int unsigned CW = $clog2(XLEN);

    logic [CW-1:0]     count;
    logic [2*XLEN-1:0] acc;      // mul: {partial high, multiplier}; div: {remainder, dividend->quotient}
    logic [XLEN-1:0]   opnd;     // multiplicand or divisor magnitude
    logic              neg;      // two's-complement the selected result at the end
    logic              sel;      // mul: take high half; div: take remainder

    logic              is_mul, is_div, a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] mul_next, mul_full, div_next;
    logic [XLEN-1:0]   mul_fin, div_pick, div_fin;

    // Operand decode: signed operations run on magnitudes and fix the sign at the end.
    always_comb begin
        is_mul   = (alu_op >= 5'd14) && (alu_op <= 5'd17);
        is_div   = (alu_op >= 5'd18) && (alu_op <= 5'd21);
        a_signed = (alu_op == 5'd14) || (alu_op == 5'd15) || (alu_op == 5'd16) ||
                   (alu_op == 5'd18) || (alu_op == 5'd20);
        b_signed = (alu_op == 5'd14) || (alu_op == 5'd15) ||
                   (alu_op == 5'd18) || (alu_op == 5'd20);
        a_neg    = a_signed && data_one[XLEN-1];
        b_neg    = b_signed && data_two[XLEN-1];
        mag_a    = a_neg ? -data_one : data_one;
        mag_b    = b_neg ? -data_two : data_two;
    end

    // One multiply step (add then shift right) and one restoring-divide step.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next  = {mul_sum, acc[XLEN-1:1]};
        mul_full  = neg ? -mul_next : mul_next;
        mul_fin   = sel ? mul_full[2*XLEN-1:XLEN] : mul_full[XLEN-1:0];
        div_shift = acc[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, opnd};
        if (!div_diff[XLEN]) begin
            div_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else begin
            div_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end
        div_pick  = sel ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];
        div_fin   = neg ? -div_pick : div_pick;
    end

    assign md_op = is_mul || is_div;
    assign busy  = (state == MUL) || (state == DIV);
`else
    assign md_op = 1'b0;
    assign busy  = 1'b0;
`endif

    // Control FSM with registered result, zero flag and out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            alive      <= 1'b0;
            out_valid  <= 1'b0;
            alu_result <= '0;
            zero       <= 1'b1;
`ifdef MULTICYCLE_ALU_MULDIV_EN
            count      <= '0;
            acc        <= '0;
            opnd       <= '0;
            neg        <= 1'b0;
            sel        <= 1'b0;
`endif
        end else begin
            alive <= 1'b1;
            if (flush) begin
                state     <= IDLE;
                out_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if ((state == DONE) && out_ready) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                        end
                        if (accept && !md_op) begin
                            state      <= DONE;
                            out_valid  <= 1'b1;
                            alu_result <= single_res;
                            zero       <= (single_res == '0);
                        end
`ifdef MULTICYCLE_ALU_MULDIV_EN
                        if (accept && md_op) begin
                            state     <= is_mul ? MUL : DIV;
                            out_valid <= 1'b0;
                            count     <= CW'(XLEN - 1);
                            opnd      <= is_mul ? mag_a : mag_b;
                            acc       <= is_mul ? {XLEN'(0), mag_b} : {XLEN'(0), mag_a};
                            sel       <= is_mul ? (alu_op != 5'd14)
                                                : ((alu_op == 5'd20) || (alu_op == 5'd21));
                            // Remainder takes the dividend's sign; a zero divisor keeps
                            // the all-ones quotient unsigned.
                            if (is_mul) begin
                                neg <= a_neg ^ b_neg;
                            end else if ((alu_op == 5'd20) || (alu_op == 5'd21)) begin
                                neg <= a_neg;
                            end else begin
                                neg <= (a_neg ^ b_neg) && (data_two != '0);
                            end
                        end
`endif
                    end
`ifdef MULTICYCLE_ALU_MULDIV_EN
                    MUL: begin
                        acc   <= mul_next;
                        count <= count - CW'(1);
                        if (count == '0) begin
                            state      <= DONE;
                            out_valid  <= 1'b1;
                            alu_result <= mul_fin;
                            zero       <= (mul_fin == '0);
                        end
                    end
                    DIV: begin
                        acc   <= div_next;
                        count <= count - CW'(1);
                        if (count == '0) begin
                            state      <= DONE;
                            out_valid  <= 1'b1;
                            alu_result <= div_fin;
                            zero       <= (div_fin == '0);
                        end
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: directed vector table, hand-written handshake/flush/reset
// sequences and randomized operations checked against an arithmetic reference model.
// Latency is counted in rising edges with the accepting edge counted as edge 1.
module tb_multicycle_alu;
    localparam int unsigned XLEN = 32;
`ifdef MULTICYCLE_ALU_MULDIV_EN
    localparam bit MD_ON = 1'b1;
`else
    localparam bit MD_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      alu_op;
    logic [XLEN-1:0] data_one;
    logic [XLEN-1:0] data_two;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_result;
    logic            zero;
    logic            busy;

    int tests = 0;
    int fails = 0;

    multicycle_alu #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .alu_op(alu_op),
        .data_one(data_one), .data_two(data_two),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_result(alu_result), .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } vec_t;

    vec_t vecs[$];

    task automatic do_check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit is_md(input logic [4:0] op);
        return MD_ON && (op >= 5'd14) && (op <= 5'd21);
    endfunction

    function automatic int exp_lat(input logic [4:0] op);
        return is_md(op) ? int'(XLEN) + 1 : 1;
    endfunction

    // Reference results straight from the operation definitions using 64-bit arithmetic.
    function automatic logic [31:0] ref_model(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        logic [4:0]  sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        sh = b[4:0];
        if (!MD_ON && (op >= 5'd14) && (op <= 5'd21)) return 32'h0;
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a << sh;
            5'd3:  return (sa < sb) ? 32'd1 : 32'd0;
            5'd4:  return (ua < ub) ? 32'd1 : 32'd0;
            5'd5:  return a ^ b;
            5'd6:  begin p = 64'(sa >>> sh); return p[31:0]; end
            5'd7:  return a >> sh;
            5'd8:  return a | b;
            5'd9:  return a & b;
            5'd10: return (a == b) ? 32'h0 : 32'hFFFFFFFF;
            5'd11: return (a != b) ? 32'h0 : 32'hFFFFFFFF;
            5'd12: return (sa < sb)  ? 32'h0 : 32'hFFFFFFFF;
            5'd13: return (sa >= sb) ? 32'h0 : 32'hFFFFFFFF;
            5'd14: begin p = 64'(sa * sb); return p[31:0]; end
            5'd15: begin p = 64'(sa * sb); return p[63:32]; end
            5'd16: begin p = 64'(sa * ub); return p[63:32]; end
            5'd17: begin p = 64'(ua * ub); return p[63:32]; end
            5'd18: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                p = 64'(sa / sb); return p[31:0];
            end
            5'd19: return (b == 0) ? 32'hFFFFFFFF : a / b;
            5'd20: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                p = 64'(sa % sb); return p[31:0];
            end
            5'd21: return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'h7FFFFFFF;
            4:       return 32'($urandom_range(0, 40));
            default: return $urandom();
        endcase
    endfunction

    // Issue one request at a falling edge, scramble the inputs after acceptance, wait for out_valid.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic z, output int lat, output logic bz);
        alu_op   = op;
        data_one = a;
        data_two = b;
        in_valid = 1'b1;
        #1;
        do_check("in_ready before issue", 64'(in_ready), 64'd1);
        @(posedge clk);
        lat = 1;
        #1;
        in_valid = 1'b0;
        alu_op   = 5'($urandom());
        data_one = $urandom();
        data_two = $urandom();
        @(negedge clk);
        bz = busy;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        res = alu_result;
        z   = zero;
    endtask

    task automatic run_checked(input string name, input logic [4:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp);
        logic [31:0] res;
        logic        z, bz;
        int          lat;
        issue(op, a, b, res, z, lat, bz);
        do_check({name, " result"},  64'(res), 64'(exp));
        do_check({name, " zero"},    64'(z), 64'(exp == 32'h0));
        do_check({name, " latency"}, 64'(lat), 64'(exp_lat(op)));
        do_check({name, " busy"},    64'(bz), 64'(exp_lat(op) > 1));
    endtask

    initial begin
        logic        seen;
        logic [4:0]  rop;
        logic [31:0] ra, rb;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_op = '0; data_one = '0; data_two = '0;

        vecs.push_back('{"add_wrap", 5'd0,  32'hFFFFFFFF, 32'h1,        32'h0});
        vecs.push_back('{"sub",      5'd1,  32'h3,        32'h5,        32'hFFFFFFFE});
        vecs.push_back('{"sll",      5'd2,  32'h1,        32'h21,       32'h2});
        vecs.push_back('{"slt",      5'd3,  32'hFFFFFFFF, 32'h0,        32'h1});
        vecs.push_back('{"sltu",     5'd4,  32'hFFFFFFFF, 32'h0,        32'h0});
        vecs.push_back('{"xor",      5'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0});
        vecs.push_back('{"sra",      5'd6,  32'h80000000, 32'h21,       32'hC0000000});
        vecs.push_back('{"srl",      5'd7,  32'h80000000, 32'h21,       32'h40000000});
        vecs.push_back('{"or",       5'd8,  32'hF0,       32'h0F,       32'hFF});
        vecs.push_back('{"and",      5'd9,  32'hF0,       32'h3C,       32'h30});
        vecs.push_back('{"beq",      5'd10, 32'h5,        32'h5,        32'h0});
        vecs.push_back('{"bne",      5'd11, 32'h5,        32'h5,        32'hFFFFFFFF});
        vecs.push_back('{"blt",      5'd12, 32'hFFFFFFFF, 32'h0,        32'h0});
        vecs.push_back('{"bge",      5'd13, 32'hFFFFFFFF, 32'h0,        32'hFFFFFFFF});
        vecs.push_back('{"rsv22",    5'd22, 32'h123,      32'h456,      32'h0});
        vecs.push_back('{"rsv31",    5'd31, 32'hFFFFFFFF, 32'h1,        32'h0});
        vecs.push_back('{"mulhu",    5'd17, 32'hFFFFFFFF, 32'hFFFFFFFF, MD_ON ? 32'hFFFFFFFE : 32'h0});
        vecs.push_back('{"mul",      5'd14, 32'hFFFFFFFD, 32'h7,        MD_ON ? 32'hFFFFFFEB : 32'h0});
        vecs.push_back('{"mulh",     5'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0});
        vecs.push_back('{"mulhsu",   5'd16, 32'hFFFFFFFF, 32'hFFFFFFFF, MD_ON ? 32'hFFFFFFFF : 32'h0});
        vecs.push_back('{"div_ovf",  5'd18, 32'h80000000, 32'hFFFFFFFF, MD_ON ? 32'h80000000 : 32'h0});
        vecs.push_back('{"rem_ovf",  5'd20, 32'h80000000, 32'hFFFFFFFF, 32'h0});
        vecs.push_back('{"remu_dz",  5'd21, 32'h7,        32'h0,        MD_ON ? 32'h7 : 32'h0});
        vecs.push_back('{"divu_dz",  5'd19, 32'h7,        32'h0,        MD_ON ? 32'hFFFFFFFF : 32'h0});
        vecs.push_back('{"div_dz",   5'd18, 32'hFFFFFFF9, 32'h0,        MD_ON ? 32'hFFFFFFFF : 32'h0});
        vecs.push_back('{"rem_dz",   5'd20, 32'hFFFFFFF9, 32'h0,        MD_ON ? 32'hFFFFFFF9 : 32'h0});
        vecs.push_back('{"div_neg",  5'd18, 32'hFFFFFFF9, 32'h2,        MD_ON ? 32'hFFFFFFFD : 32'h0});
        vecs.push_back('{"rem_neg",  5'd20, 32'hFFFFFFF9, 32'h2,        MD_ON ? 32'hFFFFFFFF : 32'h0});

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        do_check("reset out_valid",  64'(out_valid),  64'd0);
        do_check("reset alu_result", 64'(alu_result), 64'd0);
        do_check("reset zero",       64'(zero),       64'd1);
        do_check("reset busy",       64'(busy),       64'd0);
        do_check("reset in_ready",   64'(in_ready),   64'd0);
        rst_n = 1'b1;
        #1;
        do_check("in_ready before first edge", 64'(in_ready), 64'd0);
        @(negedge clk);
        do_check("in_ready after release", 64'(in_ready), 64'd1);

        // Directed table, issued back to back.
        foreach (vecs[i]) begin
            run_checked(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res);
        end

        // Result held while the consumer stalls.
        out_ready = 1'b0;
        @(negedge clk);
        alu_op = 5'd10; data_one = 32'd5; data_two = 32'd5; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; data_one = 32'd9;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            do_check($sformatf("hold%0d out_valid", k), 64'(out_valid),  64'd1);
            do_check($sformatf("hold%0d result", k),    64'(alu_result), 64'd0);
            do_check($sformatf("hold%0d zero", k),      64'(zero),       64'd1);
            do_check($sformatf("hold%0d in_ready", k),  64'(in_ready),   64'd0);
        end
        out_ready = 1'b1;
        #1;
        do_check("hold release in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        do_check("hold consumed", 64'(out_valid), 64'd0);

        // Flush ten edges into a divide (or while a held result waits).
        out_ready = 1'b0;
        alu_op = 5'd18; data_one = 32'd100; data_two = 32'd7; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        do_check("flush out_valid", 64'(out_valid), 64'd0);
        do_check("flush busy",      64'(busy),      64'd0);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        do_check("flush no result", 64'(seen), 64'd0);
        out_ready = 1'b1;
        run_checked("post_flush_add", 5'd0, 32'd2, 32'd3, 32'd5);

        // Flush and a request on the same edge: nothing is accepted.
        @(negedge clk);
        alu_op = 5'd0; data_one = 32'd1; data_two = 32'd1; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        do_check("flush beats in_valid", 64'(seen), 64'd0);

        // Reset in the middle of an operation discards it.
        out_ready = 1'b0;
        alu_op = 5'd17; data_one = 32'hFFFFFFFF; data_two = 32'hFFFFFFFF; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        do_check("midreset out_valid", 64'(out_valid),  64'd0);
        do_check("midreset busy",      64'(busy),       64'd0);
        do_check("midreset result",    64'(alu_result), 64'd0);
        do_check("midreset in_ready",  64'(in_ready),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        do_check("midreset no result", 64'(seen), 64'd0);

        // Randomized operations against the reference model.
        for (int n = 0; n < 250; n++) begin
            rop = 5'($urandom_range(0, 31));
            ra  = pick();
            rb  = pick();
            run_checked($sformatf("rand%0d op%0d a=%h b=%h", n, rop, ra, rb), rop, ra, rb,
                        ref_model(rop, ra, rb));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the operand and result width (legal values 8, 16, 32, 64).
REQ-002 SHALL have parameter SHW, default $clog2(XLEN), giving the number of shift-amount bits taken from data_two.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port flush, input, 1 bit: synchronous abort.
REQ-006 SHALL have port in_valid, input, 1 bit: request valid.
REQ-007 SHALL have port in_ready, output, 1 bit: request accepted on an edge when in_valid && in_ready && !flush.
REQ-008 SHALL have port alu_op, input, 5 bits: operation code.
REQ-009 SHALL have ports data_one and data_two, input, XLEN bits each: operands.
REQ-010 SHALL have port out_valid, output, 1 bit: result valid.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-012 SHALL have port alu_result, output, XLEN bits: registered result.
REQ-013 SHALL have port zero, output, 1 bit: registered, equals (alu_result == 0) for the same result.
REQ-014 SHALL have port busy, output, 1 bit: high while in state MUL or DIV.

Function
REQ-015 SHALL implement operation codes 0-13 as: ADD, SUB, SLL, SLT, SLTU, XOR, SRA, SRL, OR, AND, BEQ, BNE, BLT, BGE.
REQ-016 Branch codes 10-13 SHALL return 0 when the condition holds, otherwise all-ones.
REQ-017 Shift codes SHALL use only data_two[SHW-1:0] as the shift amount.
REQ-018 Codes 0-13 SHALL be single-cycle: out_valid rises on the edge after acceptance.
REQ-019 SHALL implement codes 14-17 as MUL, MULH, MULHSU, MULHU, using iterative shift-add, one bit per cycle.
REQ-020 SHALL implement codes 18-21 as DIV, DIVU, REM, REMU, using restoring division, one bit per cycle.
REQ-021 Codes 14-21 SHALL raise out_valid exactly XLEN+1 edges after acceptance.
REQ-022 Codes 22-31 SHALL be treated as single-cycle and return result 0 with zero=1.
REQ-023 FSM states SHALL be IDLE, MUL, DIV and DONE.
REQ-024 From IDLE, an accepted single-cycle op SHALL go to DONE; accepted codes 14-17 SHALL go to MUL; accepted codes 18-21 SHALL go to DIV.
REQ-025 MUL and DIV SHALL go to DONE when the bit counter reaches 0.
REQ-026 DONE SHALL go to IDLE on out_valid && out_ready.
REQ-027 in_ready SHALL equal (state==IDLE), or (state==DONE && out_ready), so back-to-back issue is possible with no bubble.
REQ-028 alu_result, zero and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-029 Divide by zero: DIV/DIVU SHALL return all-ones; REM/REMU SHALL return data_one.
REQ-030 Signed overflow (most-negative / -1): DIV SHALL return the most-negative value; REM SHALL return 0.
REQ-031 MULH/MULHSU/MULHU SHALL return the upper XLEN bits of the 2*XLEN product; MUL SHALL return the lower XLEN bits.
REQ-032 flush SHALL force the FSM to IDLE and clear out_valid on the next edge from any state.
REQ-033 When flush and in_valid coincide, flush SHALL win and no request is accepted.
REQ-034 Operands SHALL be captured at acceptance; later input changes SHALL not affect the in-flight operation.

Reset
REQ-035 While rst_n=0, the FSM SHALL be in IDLE and out_valid=0, alu_result=0, zero=1, busy=0.
REQ-036 While rst_n=0, in_ready SHALL be 0; it is 1 from the first edge after reset release.
REQ-037 Assertion of rst_n mid-operation SHALL discard the operation immediately; no result is produced.

Configuration
REQ-038 With macro MULTICYCLE_ALU_MULDIV_EN defined, codes 14-21 SHALL behave as specified above.
REQ-039 Without MULTICYCLE_ALU_MULDIV_EN, the MUL/DIV states and datapath SHALL be absent, and codes 14-21 SHALL behave as reserved codes (single-cycle, result 0), with busy tied 0.

Verification
REQ-040 XLEN=32: ADD 0xFFFFFFFF+1 -> alu_result 0, zero=1, out_valid one edge after accept.
REQ-041 SRA 0x80000000 by data_two=0x21 -> shift amount 1 -> 0xC0000000.
REQ-042 MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE after 33 edges; busy high during MUL.
REQ-043 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REMU 7/0 -> 7; DIVU 7/0 -> 0xFFFFFFFF.
REQ-044 Hold out_ready=0 for 5 cycles after BEQ 5,5 -> result 0 and zero=1 held stable; in_ready=0 until out_ready=1.
REQ-045 Flush at cycle 10 of a DIV -> out_valid never rises; next ADD 2+3 returns 5 with normal latency.
